// File: rtl/dmem_responder.sv
// Word-organised data memory behind a valid/ready request and a one-shot response.
// A request is accepted only in IDLE, optionally waits WAIT_CYCLES cycles, commits in
// a single edge, then presents resp_valid for exactly one cycle before returning to IDLE.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned IDX_W = ADDR_W - 2;
  localparam int unsigned DEPTH = 32'd1 << IDX_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic               err_q, err_d;
  logic               req_ready_q, req_ready_d;
  logic               resp_valid_q, resp_valid_d;
  logic               busy_q, busy_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_err_q, resp_err_d;

  // Zero at time 0 only; reset deliberately leaves contents alone.
  logic [31:0]        mem_q [DEPTH] = '{default: 32'h0};

  logic               accept_c;
  logic               req_err_c;
  logic [IDX_W-1:0]   req_idx_c;
  logic               commit_c;
  logic               mem_we_c;
  logic               acc_wr_c;
  logic [IDX_W-1:0]   acc_idx_c;
  logic [31:0]        acc_wdata_c;
  logic [3:0]         acc_be_c;
  logic               acc_err_c;

  assign accept_c  = req_valid & req_ready_q;
  assign req_err_c = (req_addr[1:0] != 2'b00) | ((req_addr >> ADDR_W) != 32'd0);
  assign req_idx_c = req_addr[ADDR_W-1:2];

  // Zero-wait builds commit on the accept edge, so the access uses the live request.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_wr_c    = req_write;
      acc_idx_c   = req_idx_c;
      acc_wdata_c = req_wdata;
      acc_be_c    = req_be;
      acc_err_c   = req_err_c;
    end else begin
      acc_wr_c    = wr_q;
      acc_idx_c   = idx_q;
      acc_wdata_c = wdata_q;
      acc_be_c    = be_q;
      acc_err_c   = err_q;
    end
  end

  // Next-state, request latch, commit strobe and response/output register inputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    resp_err_d = resp_err_q;
    commit_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          wr_d    = req_write;
          idx_d   = req_idx_c;
          wdata_d = req_wdata;
          be_d    = req_be;
          err_d   = req_err_c;
          if (WAIT_CYCLES == 0) begin
            commit_c = 1'b1;
            state_d  = S_RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          commit_c = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (commit_c) begin
      rdata_d    = (acc_wr_c | acc_err_c) ? 32'h0 : mem_q[acc_idx_c];
      resp_err_d = acc_err_c;
    end

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
    busy_d       = (state_d != S_IDLE);
  end

  // Stores land only when the commit edge is reached without reset.
  assign mem_we_c = commit_c & acc_wr_c & ~acc_err_c & ~reset;

  // Byte-enabled memory write; no reset on the array.
  always_ff @(posedge clock) begin
    if (mem_we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be_c[b]) begin
          mem_q[acc_idx_c][8*b +: 8] <= acc_wdata_c[8*b +: 8];
        end
      end
    end
  end

  // Control, latch and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= 32'h0;
      be_q         <= 4'h0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      rdata_q      <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      idx_q        <= idx_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      err_q        <= err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      rdata_q      <= rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = busy_q;

endmodule
